// File: rtl/bus_pkg.sv
// Shared bus typedefs, I/O port map and UART TX state encoding for the I/O-space peripherals.
package bus_pkg;
  localparam int BUS_DATA_W = 8;
  localparam int BUS_ADDR_W = 16;

  typedef logic [BUS_DATA_W-1:0] bus_data_t;
  typedef logic [BUS_ADDR_W-1:0] bus_addr_t;

  localparam logic [7:0] UART_TX_IO_ADDR = 8'h00;
  localparam int         UART_STAT_OFS   = 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  function automatic logic [7:0] io_stat_addr(input logic [7:0] base);
    return base + 8'(UART_STAT_OFS);
  endfunction
endpackage

// File: rtl/bus_io_uart_tx_sync_fifo.sv
// Generic synchronous FIFO; pop_data shows the head entry combinationally while not empty.
// Pushes while full and pops while empty are dropped; full/empty decode a registered count.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem_q[rd_ptr_q];

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end
endmodule

// File: rtl/bus_io_uart_tx.sv
// I/O-port UART transmitter: bus writes to IO_ADDR are queued and sent 8N1, LSB first; buswait_n stalls writes while full.
// Optional status read port at IO_ADDR+1 when UART_TX_STATUS_READ_EN is defined.
module bus_io_uart_tx
  import bus_pkg::*;
#(
  parameter int         DATA_WIDTH   = BUS_DATA_W,
  parameter int         ADDR_WIDTH   = BUS_ADDR_W,
  parameter logic [7:0] IO_ADDR      = UART_TX_IO_ADDR,
  parameter int         CLKS_PER_BIT = 16,
  parameter int         FIFO_DEPTH   = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  iorq_n,
  input  logic                  rd_n,
  input  logic                  wr_n,
  input  logic [ADDR_WIDTH-1:0] addr,
  inout  wire  [DATA_WIDTH-1:0] data,
  output logic                  buswait_n,
  output logic                  txd,
  output logic                  tx_idle
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int NW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
  localparam logic [NW-1:0] BIT_LAST = NW'(DATA_WIDTH - 1);

  logic                  wr_sel, push, pop, full, empty;
  logic [DATA_WIDTH-1:0] pop_data;

  tx_state_t             state_q, state_d;
  logic [BW-1:0]         baud_q, baud_d;
  logic [NW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                  txd_q, txd_d;

  // Case-equality keeps undriven or unknown strobes from selecting the port.
  assign wr_sel    = (iorq_n === 1'b0) && (wr_n === 1'b0) && (addr[7:0] == IO_ADDR);
  assign push      = wr_sel & ~full;
  assign buswait_n = ~(wr_sel & full);
  assign txd       = txd_q;
  assign tx_idle   = empty & (state_q == IDLE);

  logic unused_addr;
  assign unused_addr = ^addr[ADDR_WIDTH-1:8];

`ifdef UART_TX_STATUS_READ_EN
  logic                  rd_sel;
  logic [DATA_WIDTH-1:0] status;
  assign rd_sel = (iorq_n === 1'b0) && (rd_n === 1'b0) && (addr[7:0] == io_stat_addr(IO_ADDR));
  assign status = DATA_WIDTH'({tx_idle, empty, full});
  assign data   = rd_sel ? status : {DATA_WIDTH{1'bz}};
`else
  logic unused_rd;
  assign unused_rd = rd_n;
  assign data      = {DATA_WIDTH{1'bz}};
`endif

  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (data),
    .pop       (pop),
    .pop_data  (pop_data),
    .full      (full),
    .empty     (empty)
  );

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    pop     = 1'b0;
    txd_d   = 1'b1;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shreg_d = pop_data;
          baud_d  = BAUD_MAX;
          state_d = START;
        end
      end
      START: begin
        if (baud_q == '0) begin
          baud_d  = BAUD_MAX;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q - BW'(1);
        end
      end
      DATA: begin
        if (baud_q == '0) begin
          baud_d = BAUD_MAX;
          if (bit_q == BIT_LAST) begin
            state_d = STOP;
          end else begin
            bit_d   = bit_q + NW'(1);
            shreg_d = shreg_q >> 1;
          end
        end else begin
          baud_d = baud_q - BW'(1);
        end
      end
      STOP: begin
        // Chain the next character straight into its start bit.
        if (baud_q == '0) begin
          if (!empty) begin
            pop     = 1'b1;
            shreg_d = pop_data;
            baud_d  = BAUD_MAX;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q - BW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shreg_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      txd_q   <= txd_d;
    end
  end
endmodule
